// File: rtl/gnrl_clkgate_pkg.sv
// Shared types for the general clock-gate enable controller and its bench/monitor.
// Output decode helper maps a state to {clk_en, clk_rdy, off_req}.
package gnrl_clkgate_pkg;

  typedef enum logic [1:0] {
    CG_RUN     = 2'd0,
    CG_OFF_REQ = 2'd1,
    CG_OFF     = 2'd2,
    CG_WAKE    = 2'd3
  } cg_state_e;

  function automatic logic [2:0] cg_decode(input cg_state_e s);
    logic [2:0] d;
    case (s)
      CG_RUN:     d = 3'b110;
      CG_OFF_REQ: d = 3'b111;
      CG_OFF:     d = 3'b000;
      CG_WAKE:    d = 3'b100;
      default:    d = 3'b110;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/gnrl_clkgate_ctrl_if.sv
// Activity/handshake bundle between the gated domain and the clock-gate enable controller.
// master = gated domain side, slave = controller.
interface gnrl_clkgate_ctrl_if
  import gnrl_clkgate_pkg::*;
#(
  parameter int STAT_W = 32
);
  logic              i_busy;
  logic              i_wake;
  logic              i_force_on;
  logic              i_off_ack;
  logic              i_stat_clr;
  logic              o_off_req;
  logic              o_clk_en;
  logic              o_clk_rdy;
  cg_state_e         o_state;
  logic [STAT_W-1:0] o_gated_cnt;

  modport master (
    output i_busy, i_wake, i_force_on, i_off_ack, i_stat_clr,
    input  o_off_req, o_clk_en, o_clk_rdy, o_state, o_gated_cnt
  );

  modport slave (
    input  i_busy, i_wake, i_force_on, i_off_ack, i_stat_clr,
    output o_off_req, o_clk_en, o_clk_rdy, o_state, o_gated_cnt
  );
endinterface

// File: rtl/gnrl_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module gnrl_sat_cnt #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;

  // Counter register: holds at all-ones instead of wrapping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/gnrl_clkgate_ctrl.sv
// Enable controller in front of the general clock gate: idle timeout, quiesce handshake, wake ramp.
// Optional gated-cycle statistic counter enabled by macro CLKGATE_STAT_EN.
module gnrl_clkgate_ctrl
  import gnrl_clkgate_pkg::*;
#(
  parameter int IDLE_CYC = 16,
  parameter int WAKE_CYC = 2,
  parameter int STAT_W   = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  gnrl_clkgate_ctrl_if.slave cg_bus
);
  localparam int IDLE_W = $clog2(IDLE_CYC + 1);
  localparam int WAKE_W = $clog2(WAKE_CYC + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYC - 1);
  localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYC - 1);

  cg_state_e         r_state;
  cg_state_e         w_state_nxt;
  logic [IDLE_W-1:0] r_idle_cnt;
  logic [IDLE_W-1:0] w_idle_nxt;
  logic [WAKE_W-1:0] r_wake_cnt;
  logic [WAKE_W-1:0] w_wake_nxt;
  logic              r_off_req;
  logic              r_clk_en;
  logic              r_clk_rdy;
  logic              w_act;

  assign w_act = cg_bus.i_busy | cg_bus.i_wake | cg_bus.i_force_on;

  // Next-state and counter logic; counters only run in their own state and restart at 0 otherwise.
  always_comb begin
    w_state_nxt = r_state;
    w_idle_nxt  = '0;
    w_wake_nxt  = '0;
    case (r_state)
      CG_RUN: begin
        if (w_act) begin
          w_idle_nxt = '0;
        end else if (r_idle_cnt == IDLE_LAST) begin
          w_state_nxt = CG_OFF_REQ;
        end else begin
          w_idle_nxt = r_idle_cnt + IDLE_W'(1);
        end
      end
      CG_OFF_REQ: begin
        if (w_act) begin
          w_state_nxt = CG_RUN;
        end else if (cg_bus.i_off_ack) begin
          w_state_nxt = CG_OFF;
        end else begin
          w_state_nxt = CG_OFF_REQ;
        end
      end
      CG_OFF: begin
        if (w_act) begin
          w_state_nxt = CG_WAKE;
        end else begin
          w_state_nxt = CG_OFF;
        end
      end
      CG_WAKE: begin
        if (r_wake_cnt == WAKE_LAST) begin
          w_state_nxt = CG_RUN;
        end else begin
          w_wake_nxt = r_wake_cnt + WAKE_W'(1);
        end
      end
      default: begin
        w_state_nxt = CG_RUN;
      end
    endcase
  end

  // State/counter registers; outputs are decoded from the next state so they flop alongside it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= CG_RUN;
      r_idle_cnt <= '0;
      r_wake_cnt <= '0;
      r_clk_en   <= 1'b1;
      r_clk_rdy  <= 1'b1;
      r_off_req  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idle_cnt <= w_idle_nxt;
      r_wake_cnt <= w_wake_nxt;
      {r_clk_en, r_clk_rdy, r_off_req} <= cg_decode(w_state_nxt);
    end
  end

  assign cg_bus.o_state   = r_state;
  assign cg_bus.o_clk_en  = r_clk_en;
  assign cg_bus.o_clk_rdy = r_clk_rdy;
  assign cg_bus.o_off_req = r_off_req;

`ifdef CLKGATE_STAT_EN
  logic              w_in_off;
  logic [STAT_W-1:0] w_gated_cnt;

  assign w_in_off = (r_state == CG_OFF);

  gnrl_sat_cnt #(
    .W (STAT_W)
  ) u_gated_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_inc (w_in_off),
    .i_clr (cg_bus.i_stat_clr),
    .o_cnt (w_gated_cnt)
  );

  assign cg_bus.o_gated_cnt = w_gated_cnt;
`else
  assign cg_bus.o_gated_cnt = '0;
`endif

endmodule

// File: tb/tb_gnrl_clkgate_ctrl.sv
// Scoreboard bench for gnrl_clkgate_ctrl: driver pushes reference-model expectations, monitor pops and compares.
module tb_gnrl_clkgate_ctrl;
  import gnrl_clkgate_pkg::*;

  localparam int IDLE_CYC = 16;
  localparam int WAKE_CYC = 2;
  localparam int STAT_W   = 32;
  localparam int M_RUN = 0, M_ASK = 1, M_OFF = 2, M_WAKE = 3;

  typedef struct packed {
    logic              off_req;
    logic              clk_en;
    logic              rdy;
    logic [1:0]        st;
    logic [STAT_W-1:0] gcnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gnrl_clkgate_ctrl_if #(.STAT_W(STAT_W)) bus ();

  gnrl_clkgate_ctrl #(
    .IDLE_CYC (IDLE_CYC),
    .WAKE_CYC (WAKE_CYC),
    .STAT_W   (STAT_W)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .cg_bus (bus)
  );

  exp_t exp_q[$];
  exp_t pend;
  bit   have_pend = 1'b0;
  int   total = 0;
  int   bad   = 0;

  // Reference model: mode plus "how long has it been" counters
  int                m_mode  = M_RUN;
  int                m_quiet = 0;
  int                m_wage  = 0;
  logic [STAT_W-1:0] m_gated = '0;

  task automatic model_step(input bit r, input bit act, input bit ack, input bit clr);
    if (r) begin
      m_mode  = M_RUN;
      m_quiet = 0;
      m_gated = '0;
    end else begin
`ifdef CLKGATE_STAT_EN
      if (clr) m_gated = '0;
      else if (m_mode == M_OFF && m_gated != {STAT_W{1'b1}}) m_gated = m_gated + 1;
`endif
      case (m_mode)
        M_RUN: begin
          if (act) m_quiet = 0;
          else begin
            m_quiet++;
            if (m_quiet == IDLE_CYC) begin m_mode = M_ASK; m_quiet = 0; end
          end
        end
        M_ASK: begin
          if (act) m_mode = M_RUN;
          else if (ack) m_mode = M_OFF;
        end
        M_OFF: begin
          if (act) begin m_mode = M_WAKE; m_wage = 0; end
        end
        default: begin
          m_wage++;
          if (m_wage == WAKE_CYC) begin m_mode = M_RUN; m_quiet = 0; end
        end
      endcase
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.off_req = (m_mode == M_ASK);
    e.clk_en  = (m_mode != M_OFF);
    e.rdy     = (m_mode == M_RUN) || (m_mode == M_ASK);
    case (m_mode)
      M_RUN:   e.st = CG_RUN;
      M_ASK:   e.st = CG_OFF_REQ;
      M_OFF:   e.st = CG_OFF;
      default: e.st = CG_WAKE;
    endcase
    e.gcnt = m_gated;
    return e;
  endfunction

  task automatic drive(input bit r, input bit b, input bit w, input bit f, input bit a, input bit c);
    @(posedge clk);
    #1;
    if (have_pend) exp_q.push_back(pend);
    rst            = r;
    bus.i_busy     = b;
    bus.i_wake     = w;
    bus.i_force_on = f;
    bus.i_off_ack  = a;
    bus.i_stat_clr = c;
    model_step(r, b | w | f, a, c);
    pend      = model_out();
    have_pend = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string name, input logic [STAT_W-1:0] got, input logic [STAT_W-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at t=%0t", name, got, want, $time);
    end
  endtask

  // Monitor: compares the DUT against the oldest pending expectation, away from the active edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("off_req", STAT_W'(bus.o_off_req), STAT_W'(e.off_req));
        chk("clk_en", STAT_W'(bus.o_clk_en), STAT_W'(e.clk_en));
        chk("clk_rdy", STAT_W'(bus.o_clk_rdy), STAT_W'(e.rdy));
        chk("state", STAT_W'(bus.o_state), STAT_W'(e.st));
        chk("gated_cnt", bus.o_gated_cnt, e.gcnt);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_busy = 1'b0; bus.i_wake = 1'b0; bus.i_force_on = 1'b0;
    bus.i_off_ack = 1'b0; bus.i_stat_clr = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(20);                                   // idle timeout to OFF_REQ
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);  // ack -> OFF
    idle(5);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);  // wake pulse
    idle(5);
    idle(13);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);  // busy beats ack
    idle(18);
    for (int i = 0; i < 100; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, i[0], 1'b0);
    idle(16);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(10);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);  // stat clear while OFF
    idle(3);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);  // reset from OFF
    idle(2);
    for (int s = 0; s < 250; s++) begin
      int len;
      bit quiet;
      len   = $urandom_range(1, 30);
      quiet = ($urandom_range(0, 1) == 0);
      for (int i = 0; i < len; i++) begin
        drive($urandom_range(0, 299) == 0,
              !quiet && ($urandom_range(0, 1) == 0),
              !quiet && ($urandom_range(0, 7) == 0),
              !quiet && ($urandom_range(0, 15) == 0),
              $urandom_range(0, 2) == 0,
              $urandom_range(0, 19) == 0);
      end
    end
    @(posedge clk);
    #1;
    exp_q.push_back(pend);
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
